sdf_edge_capture: RTL and testbench

- Downstream consumer of the registered outputs q1/q2 of the conditional-path DFF stage.
- Detects toggles on q1/q2 inside an armed capture window and timestamps each one.
- Buffers event records in a small first-word-fall-through FIFO with a valid/ready output.
- Keeps saturating per-signal edge counters; used as the capture/observation stage for SDF timing test designs.

---
 rtl/sdf_edge_capture.sv | 117 +++++++++++
 tb/tb_sdf_edge_capture.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sdf_edge_capture.sv
// Edge capture stage for q1/q2: timestamps toggles inside an armed window,
// queues records in a first-word-fall-through FIFO and keeps saturating edge counts.
module sdf_edge_capture #(
  parameter int TS_WIDTH  = 8,
  parameter int CNT_WIDTH = 8,
  parameter int DEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  q1,
  input  logic                  q2,
  input  logic                  arm,
  input  logic                  clear,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TS_WIDTH+3:0]   out_data,
  output logic [CNT_WIDTH-1:0]  cnt_q1,
  output logic [CNT_WIDTH-1:0]  cnt_q2,
  output logic                  overflow,
  output logic [1:0]            state
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = TS_WIDTH + 4;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic                prev_q1, prev_q2;
  logic [TS_WIDTH-1:0] ts;
  logic [DW-1:0]       mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count;

  logic e1, e2, ev, capturing, push_req, full, pop, do_push, drop;
  logic [DW-1:0] rec;

  // NOTE: combinational logic uses blocking assignments with every output
  // given a default first, so no path through the block can infer a latch.
  always_comb begin
    e1        = q1 ^ prev_q1;
    e2        = q2 ^ prev_q2;
    ev        = e1 | e2;
    capturing = !clear && (state == S_ARMED || state == S_RUN);
    push_req  = capturing && ev;
    full      = (count == FULL_CNT);
    pop       = out_valid && out_ready;
    do_push   = push_req && (!full || pop);
    drop      = push_req && full && !pop;
    rec       = {q2, q1, e2, e1, ts};
  end

  // History follows the inputs even through clear so arming never sees a stale level.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q1 <= 1'b0;
      prev_q2 <= 1'b0;
    end else begin
      prev_q1 <= q1;
      prev_q2 <= q2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state    <= S_IDLE;
      ts       <= '0;
      cnt_q1   <= '0;
      cnt_q2   <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE:  if (arm) state <= S_ARMED;
        S_ARMED: if (ev) state <= S_RUN;
        S_RUN: begin
          if (&ts) state <= S_DONE;
          else     ts    <= ts + 1'b1;
        end
        default: ;
      endcase
      if (capturing && e1 && !(&cnt_q1)) cnt_q1 <= cnt_q1 + 1'b1;
      if (capturing && e2 && !(&cnt_q2)) cnt_q2 <= cnt_q2 + 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is not reset; out_data is masked while empty, so stale
  // entries are never observable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= rec;
  end

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_sdf_edge_capture.sv
// Directed bench for sdf_edge_capture: each task drives one scenario and
// compares outputs against hand-computed records {q2,q1,e2,e1,ts}.
module tb_sdf_edge_capture;

  logic        clk = 1'b0;
  logic        rst, q1, q2, arm, clear, out_ready;
  logic        out_valid, overflow;
  logic [11:0] out_data;
  logic [7:0]  cnt_q1, cnt_q2;
  logic [1:0]  state;

  int n_vec = 0;
  int n_err = 0;

  // Bench-side timestamp model: value the DUT ts register holds right now.
  int model_ts  = 0;
  bit model_run = 1'b0;

  sdf_edge_capture #(.TS_WIDTH(8), .CNT_WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .q1(q1), .q2(q2), .arm(arm), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cnt_q1(cnt_q1), .cnt_q2(cnt_q2), .overflow(overflow), .state(state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    if (model_run) begin
      if (model_ts == 255) model_run = 1'b0;
      else                 model_ts++;
    end
  endtask

  task automatic run_to(input int t);
    while (model_ts < t) step();
  endtask

  task automatic restart();
    clear = 1'b1; step(); clear = 1'b0;
    model_run = 1'b0; model_ts = 0;
    arm = 1'b1; step(); arm = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; q1 = 1'b0; q2 = 1'b0; arm = 1'b0; clear = 1'b0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    n_vec++; if (state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_vec++; if (out_data !== 12'h000) begin n_err++; $display("FAIL reset_data: got %h expected 000", out_data); end
    n_vec++; if ({cnt_q1, cnt_q2, overflow} !== 17'd0) begin n_err++;
      $display("FAIL reset_counters: got %0d/%0d/%b expected 0/0/0", cnt_q1, cnt_q2, overflow); end
  endtask

  task automatic test_arm_first_edge();
    arm = 1'b1; step(); arm = 1'b0;
    n_vec++; if (state !== 2'd1) begin n_err++; $display("FAIL armed_state: got %0d expected 1", state); end
    step(); step(); step();
    n_vec++; if (state !== 2'd1) begin n_err++; $display("FAIL armed_hold: got %0d expected 1", state); end
    out_ready = 1'b1; q1 = 1'b1; step();
    model_run = 1'b1; model_ts = 0;
    n_vec++; if (state !== 2'd2) begin n_err++; $display("FAIL run_state: got %0d expected 2", state); end
    n_vec++; if (out_valid !== 1'b1 || out_data !== 12'h500) begin n_err++;
      $display("FAIL first_record: got %b/%h expected 1/500", out_valid, out_data); end
    n_vec++; if (cnt_q1 !== 8'd1) begin n_err++; $display("FAIL first_cnt_q1: got %0d expected 1", cnt_q1); end
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL first_popped: got %b expected 0", out_valid); end
  endtask

  task automatic test_run_records();
    run_to(3); q1 = 1'b0; q2 = 1'b1; step();
    n_vec++; if (out_valid !== 1'b1 || out_data !== 12'hB03) begin n_err++;
      $display("FAIL rec_ts3: got %b/%h expected 1/b03", out_valid, out_data); end
    run_to(7); q2 = 1'b0; step();
    n_vec++; if (out_valid !== 1'b1 || out_data !== 12'h207) begin n_err++;
      $display("FAIL rec_ts7: got %b/%h expected 1/207", out_valid, out_data); end
    n_vec++; if (cnt_q1 !== 8'd2 || cnt_q2 !== 8'd2) begin n_err++;
      $display("FAIL run_counts: got %0d/%0d expected 2/2", cnt_q1, cnt_q2); end
    step();
  endtask

  task automatic test_overflow();
    logic [11:0] exp_rec [4];
    exp_rec = '{12'h500, 12'h102, 12'h504, 12'h106};
    q1 = 1'b0; q2 = 1'b0; out_ready = 1'b0;
    restart();
    q1 = 1'b1; step(); model_run = 1'b1; model_ts = 0;
    for (int k = 1; k <= 5; k++) begin
      run_to(2 * k); q1 = ~q1; step();
    end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    n_vec++; if (cnt_q1 !== 8'd6 || cnt_q2 !== 8'd0) begin n_err++;
      $display("FAIL ovf_counts: got %0d/%0d expected 6/0", cnt_q1, cnt_q2); end
    n_vec++; if (out_valid !== 1'b1 || out_data !== 12'h500) begin n_err++;
      $display("FAIL ovf_head_held: got %b/%h expected 1/500", out_valid, out_data); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (out_valid !== 1'b1 || out_data !== exp_rec[i]) begin n_err++;
        $display("FAIL ovf_pop%0d: got %b/%h expected 1/%h", i, out_valid, out_data, exp_rec[i]); end
      step();
    end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ovf_drained: got %b expected 0", out_valid); end
  endtask

  task automatic test_full_push_pop();
    logic [11:0] exp_rec [4];
    exp_rec = '{12'h102, 12'h504, 12'h106, 12'h508};
    out_ready = 1'b0;
    restart();
    q1 = ~q1; step(); model_run = 1'b1; model_ts = 0;
    for (int k = 1; k <= 3; k++) begin
      run_to(2 * k); q1 = ~q1; step();
    end
    run_to(8);
    n_vec++; if (out_valid !== 1'b1 || out_data !== 12'h500) begin n_err++;
      $display("FAIL full_head: got %b/%h expected 1/500", out_valid, out_data); end
    q1 = ~q1; out_ready = 1'b1; step(); out_ready = 1'b0;
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL full_no_ovf: got %b expected 0", overflow); end
    n_vec++; if (cnt_q1 !== 8'd5) begin n_err++; $display("FAIL full_cnt_q1: got %0d expected 5", cnt_q1); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (out_valid !== 1'b1 || out_data !== exp_rec[i]) begin n_err++;
        $display("FAIL full_pop%0d: got %b/%h expected 1/%h", i, out_valid, out_data, exp_rec[i]); end
      step();
    end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_drained: got %b expected 0", out_valid); end
  endtask

  task automatic test_ts_end();
    out_ready = 1'b1;
    restart();
    q1 = 1'b0; step(); model_run = 1'b1; model_ts = 0;
    run_to(255); q1 = 1'b1; step();
    n_vec++; if (out_valid !== 1'b1 || out_data !== 12'h5FF) begin n_err++;
      $display("FAIL end_record: got %b/%h expected 1/5ff", out_valid, out_data); end
    n_vec++; if (state !== 2'd3) begin n_err++; $display("FAIL end_state: got %0d expected 3", state); end
    q2 = 1'b1; step();
    q1 = 1'b0; step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL done_no_push: got %b expected 0", out_valid); end
    n_vec++; if (cnt_q1 !== 8'd2 || cnt_q2 !== 8'd0 || state !== 2'd3) begin n_err++;
      $display("FAIL done_hold: got %0d/%0d/%0d expected 2/0/3", cnt_q1, cnt_q2, state); end
  endtask

  task automatic test_saturate();
    out_ready = 1'b1;
    restart();
    for (int i = 0; i < 260; i++) begin
      q1 = ~q1; step();
    end
    n_vec++; if (cnt_q1 !== 8'hFF) begin n_err++; $display("FAIL sat_cnt_q1: got %0d expected 255", cnt_q1); end
    n_vec++; if (overflow !== 1'b0 || state !== 2'd3) begin n_err++;
      $display("FAIL sat_flags: got %b/%0d expected 0/3", overflow, state); end
  endtask

  task automatic test_clear();
    out_ready = 1'b0;
    restart();
    q1 = ~q1; step(); model_run = 1'b1; model_ts = 0;
    run_to(2); q1 = ~q1; step();
    n_vec++; if (out_valid !== 1'b1 || cnt_q1 !== 8'd2) begin n_err++;
      $display("FAIL clr_setup: got %b/%0d expected 1/2", out_valid, cnt_q1); end
    q1 = ~q1; clear = 1'b1; step(); clear = 1'b0;
    n_vec++; if (state !== 2'd0 || out_valid !== 1'b0 || out_data !== 12'h000) begin n_err++;
      $display("FAIL clr_flush: got %0d/%b/%h expected 0/0/000", state, out_valid, out_data); end
    n_vec++; if (cnt_q1 !== 8'd0 || cnt_q2 !== 8'd0 || overflow !== 1'b0) begin n_err++;
      $display("FAIL clr_counters: got %0d/%0d/%b expected 0/0/0", cnt_q1, cnt_q2, overflow); end
    arm = 1'b1; step(); arm = 1'b0;
    step(); step();
    n_vec++; if (state !== 2'd1 || out_valid !== 1'b0 || cnt_q1 !== 8'd0) begin n_err++;
      $display("FAIL clr_rearm: got %0d/%b/%0d expected 1/0/0", state, out_valid, cnt_q1); end
  endtask

  initial begin
    test_reset();
    test_arm_first_edge();
    test_run_records();
    test_overflow();
    test_full_push_pop();
    test_ts_end();
    test_saturate();
    test_clear();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
